packet_queue_bank: RTL and testbench
====================================

# packet_queue_bank

Per-priority packet-descriptor queue bank directly upstream of the read arbiter. The write side enqueues the head address of each stored packet into one of `num_of_priorities` FIFOs. The bank drives `prepared` (queue non-empty) to the arbiter and, on each one-hot `next_data` dequeue, returns the head address the arbiter uses as `address_to_read1`.

## Interface
- `num_of_priorities`, 8: number of priority queues.
- `address_width`, 12: SRAM packet-head address width.
- `queue_depth`, 16: entries per queue; power of two, ≥ 2.
- `clk`  in  1: single clock; all state changes on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `enq_vld`  in  1: enqueue strobe, one descriptor per cycle.
- `enq_prio`  in  $clog2(num_of_priorities): target queue.
- `enq_addr`  in  address_width: packet head address.
- `enq_drop`  out  1: one-cycle pulse; enqueue rejected, queue full.
- `next_data`  in  num_of_priorities: one-hot dequeue request from the arbiter.
- `prepared`  out  num_of_priorities: bit p = queue p non-empty.
- `full`  out  num_of_priorities: bit p = queue p holds queue_depth entries.
- `address_to_read1`  out  address_width: dequeued head address.
- `addr_vld`  out  1: `address_to_read1` valid this cycle.
- `deq_err`  out  1: one-cycle pulse; illegal dequeue request.

## Operation
- Each queue is a circular FIFO.
  - Write and read pointers are $clog2(queue_depth) bits and wrap naturally.
  - `count` is $clog2(queue_depth)+1 bits, range 0..queue_depth.
- Enqueue (`enq_vld`=1, queue q):
  - Written at `wr_ptr[q]`, which then increments.
  - If queue q is full, the enqueue is accepted only if q is dequeued in the same cycle.
  - Otherwise the descriptor is discarded, `enq_drop`=1 for that cycle, and no state changes.
- Dequeue (`next_data` has exactly one bit p set, queue p non-empty):
  - Entry at `rd_ptr[p]` is registered onto `address_to_read1` with `addr_vld`=1.
  - `rd_ptr[p]` increments.
- Illegal dequeue: `deq_err`=1 for that cycle.
  - Multiple bits set: only the lowest set index is served, if that queue is non-empty.
  - Request to an empty queue: nothing is dequeued; `addr_vld`=0.
- Simultaneous enqueue and dequeue on the same queue: both take effect and count is unchanged.
  - Empty queue: the dequeue is illegal, with no bypass; the enqueue still happens.
- Enqueue and dequeue on different queues are fully independent.
- `prepared[p]` = (count[p] != 0); `full[p]` = (count[p] == queue_depth). Both are registered and reflect the state after the previous edge.

## Timing
- Reset values, at the first edge with `rst`=1:
  - All pointers and counts = 0.
  - `prepared`=0, `full`=0, `addr_vld`=0, `address_to_read1`=0, `enq_drop`=0, `deq_err`=0.
- Reset mid-operation flushes all queues. Storage contents need not be cleared, but no stale entry may ever be dequeued.
- Enqueue at edge t: `prepared[q]` rises after edge t+1. A dequeue issued in cycle t+1 is legal.
- Dequeue latency is 1 cycle: `next_data` sampled at edge t; `address_to_read1`/`addr_vld` are valid in cycle t+1 (the cycle after edge t).
- `addr_vld` is a single-cycle pulse per dequeue. Back-to-back dequeues give one address per cycle.
- Dequeue of the last entry at edge t: `prepared[p]` falls after edge t+1.
  - The arbiter must not re-request p in the cycle between edge t and edge t+1; such a request is treated as illegal (`deq_err`).
- `enq_drop` and `deq_err` are combinational-free registered pulses, asserted in the cycle after the offending request.

## Structure
- Shared package holds:
  - Constants: `num_of_priorities`, `address_width`, `queue_depth`.
  - Derived widths: `PRIO_W`=$clog2(num_of_priorities), `PTR_W`=$clog2(queue_depth), `CNT_W`=PTR_W+1.
  - Typedef for the address bus, shared with the read arbiter.
- One sub-module, `prio_addr_fifo`: single-queue FIFO with `push`, `pop`, `din`, `dout`, `empty`, `full`.
  - Instantiated `num_of_priorities` times in a generate loop.
  - Top level decodes `enq_prio`/`next_data`, muxes `dout` and registers the outputs and pulses.

## Test plan
- Reset with `rst`=1 for 2 cycles, then idle: all outputs 0. Enqueue 0x0A5 to prio 3: `prepared`=8'h08 one cycle later. Dequeue `next_data`=8'h08: next cycle `address_to_read1`=0x0A5, `addr_vld`=1; `prepared` returns to 8'h00.
- Enqueue 16 addresses 0x100..0x10F to prio 0: `full[0]`=1. A 17th enqueue gives `enq_drop` pulse. Then 16 dequeues return 0x100..0x10F in order with no gaps; a 17th dequeue gives `deq_err`=1 and `addr_vld`=0.
- With prio 5 full, enqueue 0x3FF to prio 5 and dequeue prio 5 in the same cycle: no drop; count stays 16; 0x3FF appears as the 16th subsequent output.
- `next_data`=8'h24 with prio 2 and prio 5 both non-empty: prio 2 head served, `deq_err`=1, prio 5 untouched.
- Run 40 enq/deq cycles on prio 7 (pointer wrap), assert `rst` mid-stream: all `prepared`=0 next cycle. Post-reset enqueue 0x001 then dequeue returns 0x001, never a pre-reset entry.
- Random interleaved enqueues/dequeues on all 8 queues against a scoreboard model: per-queue order preserved; `prepared`/`full` match model counts every cycle.

Source files
------------

// File: rtl/packet_queue_bank_pkg.sv
// Shared definitions for the packet-descriptor queue bank and its read arbiter.
// Holds the bank dimensions, derived field widths, the address bus type and
// small helpers for decoding the arbiter's dequeue request vector.
package packet_queue_bank_pkg;

    localparam int num_of_priorities = 8;
    localparam int address_width     = 12;
    localparam int queue_depth       = 16;

    localparam int PRIO_W = $clog2(num_of_priorities);
    localparam int PTR_W  = $clog2(queue_depth);
    localparam int CNT_W  = PTR_W + 1;

    // Packet-head address as seen by the SRAM read port and the arbiter.
    typedef logic [address_width-1:0] addr_t;

    typedef logic [num_of_priorities-1:0] prio_vec_t;

    // Index of the lowest set bit; returns 0 for an all-zero vector.
    function automatic logic [PRIO_W-1:0] lowest_set_idx(input prio_vec_t v);
        logic [PRIO_W-1:0] idx;
        idx = {PRIO_W{1'b0}};
        for (int i = num_of_priorities - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = PRIO_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // True when more than one request bit is set.
    function automatic logic is_multi_hot(input prio_vec_t v);
        return (v & (v - prio_vec_t'(1))) != {num_of_priorities{1'b0}};
    endfunction

endpackage

// File: rtl/packet_queue_bank_if.sv
// Enqueue / dequeue bus between the write side, the read arbiter and the
// queue bank.
//   master : write side + arbiter (drives enq_* and next_data)
//   slave  : queue bank (drives prepared, full, address_to_read1 and the pulses)
interface packet_queue_bank_if;
    import packet_queue_bank_pkg::*;

    logic                   enq_vld;
    logic [PRIO_W-1:0]      enq_prio;
    addr_t                  enq_addr;
    logic                   enq_drop;
    prio_vec_t              next_data;
    prio_vec_t              prepared;
    prio_vec_t              full;
    addr_t                  address_to_read1;
    logic                   addr_vld;
    logic                   deq_err;

    modport master (
        output enq_vld, enq_prio, enq_addr, next_data,
        input  enq_drop, prepared, full, address_to_read1, addr_vld, deq_err
    );

    modport slave (
        input  enq_vld, enq_prio, enq_addr, next_data,
        output enq_drop, prepared, full, address_to_read1, addr_vld, deq_err
    );

endinterface

// File: rtl/packet_queue_bank_prio_addr_fifo.sv
// Single-priority circular FIFO of packet-head addresses.
// Ports:
//   clk, rst : clock and synchronous active-high reset (flushes pointers/count)
//   push     : write din at the write pointer (caller guarantees room, or a
//              same-cycle pop when full)
//   pop      : advance the read pointer (caller guarantees non-empty)
//   din      : address to store
//   dout     : address at the read pointer (combinational)
//   empty    : no entries held
//   full     : queue_depth entries held
module prio_addr_fifo
    import packet_queue_bank_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  logic  pop,
    input  addr_t din,
    output addr_t dout,
    output logic  empty,
    output logic  full
);

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    addr_t            mem_r [queue_depth];

    // Pointer and occupancy tracking; pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents survive reset because a zero count hides them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign empty = (count_r == {CNT_W{1'b0}});
    assign full  = (count_r == CNT_W'(queue_depth));

endmodule

// File: rtl/packet_queue_bank.sv
// Per-priority packet-descriptor queue bank feeding the read arbiter.
// Ports:
//   clk  : single rising-edge clock
//   rst  : synchronous active-high reset; flushes every queue
//   bus  : packet_queue_bank_if.slave
//          in : enq_vld, enq_prio, enq_addr, next_data (one-hot dequeue)
//          out: enq_drop, prepared, full, address_to_read1, addr_vld, deq_err
//               (all registered)
module packet_queue_bank
    import packet_queue_bank_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    packet_queue_bank_if.slave   bus
);

    prio_vec_t         push_s;
    prio_vec_t         pop_s;
    prio_vec_t         empty_s;
    prio_vec_t         full_s;
    addr_t             dout_s [num_of_priorities];

    logic [PRIO_W-1:0] deq_idx_s;
    logic              deq_req_s;
    logic              deq_ok_s;
    logic              deq_err_s;
    logic              enq_drop_s;

    prio_vec_t         prepared_r;
    prio_vec_t         full_r;
    addr_t             addr_r;
    logic              addr_vld_r;
    logic              deq_err_r;
    logic              enq_drop_r;

    for (genvar g = 0; g < num_of_priorities; g++) begin : g_queue
        prio_addr_fifo u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push_s[g]),
            .pop   (pop_s[g]),
            .din   (bus.enq_addr),
            .dout  (dout_s[g]),
            .empty (empty_s[g]),
            .full  (full_s[g])
        );
    end

    // Decode dequeue request first so a full queue can accept a same-cycle enqueue.
    always_comb begin
        pop_s      = {num_of_priorities{1'b0}};
        push_s     = {num_of_priorities{1'b0}};
        deq_ok_s   = 1'b0;
        enq_drop_s = 1'b0;
        deq_idx_s  = lowest_set_idx(bus.next_data);
        deq_req_s  = (bus.next_data != {num_of_priorities{1'b0}});

        // Only the lowest requested queue is ever served; legality uses the
        // live occupancy, not the lagging prepared flags.
        if (deq_req_s && !empty_s[deq_idx_s]) begin
            pop_s[deq_idx_s] = 1'b1;
            deq_ok_s         = 1'b1;
        end else begin
            deq_ok_s         = 1'b0;
        end

        deq_err_s = deq_req_s && (is_multi_hot(bus.next_data) || empty_s[deq_idx_s]);

        if (bus.enq_vld) begin
            if (!full_s[bus.enq_prio] || pop_s[bus.enq_prio]) begin
                push_s[bus.enq_prio] = 1'b1;
            end else begin
                enq_drop_s = 1'b1;
            end
        end else begin
            enq_drop_s = 1'b0;
        end
    end

    // Registered status flags, dequeued address and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            prepared_r <= {num_of_priorities{1'b0}};
            full_r     <= {num_of_priorities{1'b0}};
            addr_r     <= {address_width{1'b0}};
            addr_vld_r <= 1'b0;
            deq_err_r  <= 1'b0;
            enq_drop_r <= 1'b0;
        end else begin
            prepared_r <= ~empty_s;
            full_r     <= full_s;
            addr_vld_r <= deq_ok_s;
            deq_err_r  <= deq_err_s;
            enq_drop_r <= enq_drop_s;
            if (deq_ok_s) begin
                addr_r <= dout_s[deq_idx_s];
            end else begin
                addr_r <= addr_r;
            end
        end
    end

    assign bus.prepared         = prepared_r;
    assign bus.full             = full_r;
    assign bus.address_to_read1 = addr_r;
    assign bus.addr_vld         = addr_vld_r;
    assign bus.deq_err          = deq_err_r;
    assign bus.enq_drop         = enq_drop_r;

endmodule

// File: tb/tb_packet_queue_bank.sv
module tb_packet_queue_bank;
    import packet_queue_bank_pkg::*;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    packet_queue_bank_if bus ();

    packet_queue_bank dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one plain queue of addresses per priority.
    logic [11:0] mq [8][$];
    logic [11:0] exp_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, then compare after the edge.
    task automatic step(input logic r, input logic ev, input logic [2:0] ep,
                        input logic [11:0] ea, input logic [7:0] nd);
        logic [7:0] exp_prep;
        logic [7:0] exp_full;
        logic       exp_vld;
        logic       exp_drop;
        logic       exp_err;
        int         p;
        rst           = r;
        bus.enq_vld   = ev;
        bus.enq_prio  = ep;
        bus.enq_addr  = ea;
        bus.next_data = nd;
        // Status flags show the occupancy left by the previous edge.
        for (int i = 0; i < 8; i++) begin
            exp_prep[i] = (mq[i].size() != 0);
            exp_full[i] = (mq[i].size() == 16);
        end
        exp_vld  = 1'b0;
        exp_drop = 1'b0;
        exp_err  = 1'b0;
        if (r) begin
            for (int i = 0; i < 8; i++) mq[i].delete();
            exp_prep = 8'h00;
            exp_full = 8'h00;
            exp_addr = 12'h000;
        end else begin
            if (nd != 8'h00) begin
                p = 0;
                while (nd[p] == 1'b0) p++;
                if ($countones(nd) > 1) exp_err = 1'b1;
                if (mq[p].size() > 0) begin
                    exp_addr = mq[p].pop_front();
                    exp_vld  = 1'b1;
                end else begin
                    exp_err = 1'b1;
                end
            end
            if (ev) begin
                if (mq[ep].size() < 16) mq[ep].push_back(ea);
                else exp_drop = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk("prepared", 32'(bus.prepared), 32'(exp_prep));
        chk("full", 32'(bus.full), 32'(exp_full));
        chk("addr_vld", 32'(bus.addr_vld), 32'(exp_vld));
        chk("enq_drop", 32'(bus.enq_drop), 32'(exp_drop));
        chk("deq_err", 32'(bus.deq_err), 32'(exp_err));
        if (exp_vld || r) chk("address_to_read1", 32'(bus.address_to_read1), 32'(exp_addr));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 3'd0, 12'h000, 8'h00);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        exp_addr = 12'h000;

        // Reset for two cycles, then idle.
        step(1'b1, 1'b0, 3'd0, 12'h000, 8'h00);
        step(1'b1, 1'b0, 3'd0, 12'h000, 8'h00);
        idle();

        // Single enqueue / dequeue on prio 3.
        step(1'b0, 1'b1, 3'd3, 12'h0A5, 8'h00);
        idle();
        chk("prepared_p3", 32'(bus.prepared), 32'h08);
        step(1'b0, 1'b0, 3'd0, 12'h000, 8'h08);
        chk("addr_0a5", 32'(bus.address_to_read1), 32'h0A5);
        idle();
        chk("prepared_clear", 32'(bus.prepared), 32'h00);

        // Fill prio 0, overflow, drain in order, underflow.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 3'd0, 12'h100 + 12'(i), 8'h00);
        step(1'b0, 1'b1, 3'd0, 12'h1FF, 8'h00);
        chk("drop_17th", 32'(bus.enq_drop), 32'h1);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 3'd0, 12'h000, 8'h01);
        chk("last_of_16", 32'(bus.address_to_read1), 32'h10F);
        step(1'b0, 1'b0, 3'd0, 12'h000, 8'h01);
        idle();

        // Full prio 5: same-cycle enqueue and dequeue is accepted.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 3'd5, 12'h500 + 12'(i), 8'h00);
        step(1'b0, 1'b1, 3'd5, 12'h3FF, 8'h20);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 3'd0, 12'h000, 8'h20);
        step(1'b0, 1'b0, 3'd0, 12'h000, 8'h20);
        chk("addr_3ff", 32'(bus.address_to_read1), 32'h3FF);
        idle();

        // Multi-hot request: lowest index served, error flagged.
        step(1'b0, 1'b1, 3'd2, 12'h222, 8'h00);
        step(1'b0, 1'b1, 3'd5, 12'h555, 8'h00);
        idle();
        step(1'b0, 1'b0, 3'd0, 12'h000, 8'h24);
        step(1'b0, 1'b0, 3'd0, 12'h000, 8'h20);
        idle();

        // Enqueue into an empty queue while requesting it: illegal dequeue, no bypass.
        step(1'b0, 1'b1, 3'd4, 12'h444, 8'h10);
        step(1'b0, 1'b0, 3'd0, 12'h000, 8'h10);
        // Re-request right after the last entry left: illegal.
        step(1'b0, 1'b0, 3'd0, 12'h000, 8'h10);
        idle();

        // Pointer wrap on prio 7, then reset mid-stream.
        for (int i = 0; i < 40; i++)
            step(1'b0, 1'b1, 3'd7, 12'h700 + 12'(i), (i % 3 == 0) ? 8'h00 : 8'h80);
        step(1'b1, 1'b1, 3'd7, 12'h7FF, 8'h80);
        idle();
        chk("prepared_after_rst", 32'(bus.prepared), 32'h00);
        step(1'b0, 1'b0, 3'd0, 12'h000, 8'h80);
        step(1'b0, 1'b1, 3'd7, 12'h001, 8'h00);
        step(1'b0, 1'b0, 3'd0, 12'h000, 8'h80);
        chk("addr_post_rst", 32'(bus.address_to_read1), 32'h001);
        step(1'b0, 1'b0, 3'd0, 12'h000, 8'h80);

        // Randomized interleaving: fill-biased phase, then drain-biased phase.
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 400; i++) begin
                logic       ev;
                logic [7:0] nd;
                int         sel;
                ev  = ($urandom_range(99) < ((ph == 0) ? 80 : 35));
                sel = $urandom_range(99);
                if (sel < ((ph == 0) ? 30 : 70)) nd = 8'h01 << $urandom_range(7);
                else if (sel < ((ph == 0) ? 36 : 78)) nd = 8'($urandom);
                else nd = 8'h00;
                step(1'b0, ev, 3'($urandom_range(7)), 12'($urandom), nd);
            end
        end
        for (int i = 0; i < 8; i++) idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
